// File: rtl/char_scroller_if.sv
// Purpose: control, write-port and window-output bundle for char_scroller.
// Latency: pure wiring, no storage.
// Backpressure: none; writes and control are always accepted.
//
// Signals:
//   en, dir, restart           scroll control (run/freeze, direction, soft restart)
//   wr_en, wr_addr, wr_data    one-slot-per-cycle message write port
//   code0..code4, pos, tick    visible window, window start slot, step pulse
interface char_scroller_if;
    logic       en;
    logic       dir;
    logic       restart;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] code0;
    logic [2:0] code1;
    logic [2:0] code2;
    logic [2:0] code3;
    logic [2:0] code4;
    logic [2:0] pos;
    logic       tick;

    // Drives control and writes, observes the window.
    modport master (
        output en, dir, restart, wr_en, wr_addr, wr_data,
        input  code0, code1, code2, code3, code4, pos, tick
    );

    // The scroller itself.
    modport slave (
        input  en, dir, restart, wr_en, wr_addr, wr_data,
        output code0, code1, code2, code3, code4, pos, tick
    );
endinterface

// File: rtl/char_scroller.sv
// Purpose: 8-slot message of 3-bit character codes rotated past a 5-character window.
// Latency: pos/tick/codes change on the step edge; a write shows in the next cycle.
// Backpressure: none; writes are accepted every cycle, en=0 pauses the divider.
//
// Ports:
//   CLOCK_50   sole clock, rising edge
//   reset      synchronous active-high; restores RESET_MSG and clears the divider
//   bus        char_scroller_if.slave: control, write port, code0..code4, pos, tick
module char_scroller #(
    parameter int          TICK_COUNT = 50000000,
    parameter int          CNT_W      = 26,
    parameter logic [23:0] RESET_MSG  = 24'o44443210
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    char_scroller_if.slave  bus
);

    // Terminal count; TICK_COUNT may be as large as 2^CNT_W, so TICK_COUNT-1 always fits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       pos_q;
    logic             tick_q;
    logic [2:0]       msg [8];

    // Rate divider and window position.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt    <= '0;
            pos_q  <= '0;
            tick_q <= 1'b0;
        end else if (bus.restart) begin
            cnt    <= '0;
            pos_q  <= '0;
            tick_q <= 1'b0;
        end else if (bus.en) begin
            if (cnt == CNT_LAST) begin
                cnt    <= '0;
                tick_q <= 1'b1;
                // dir only matters here, at the step edge; 3-bit math wraps mod 8.
                pos_q  <= bus.dir ? (pos_q - 3'd1) : (pos_q + 3'd1);
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end else begin
            // Frozen: count is paused, not cleared.
            tick_q <= 1'b0;
        end
    end

    // Message store. restart leaves the message alone and does not block writes;
    // only reset overrides a write.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                msg[i] <= RESET_MSG[3*i +: 3];
            end
        end else if (bus.wr_en) begin
            msg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Window taps: 3-bit index sums wrap mod 8 on their own.
    assign bus.code0 = msg[pos_q];
    assign bus.code1 = msg[pos_q + 3'd1];
    assign bus.code2 = msg[pos_q + 3'd2];
    assign bus.code3 = msg[pos_q + 3'd3];
    assign bus.code4 = msg[pos_q + 3'd4];
    assign bus.pos   = pos_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_char_scroller.sv
// Purpose: directed, table-driven check of char_scroller at TICK_COUNT=4 and TICK_COUNT=1.
// Latency: outputs sampled 1 time unit after the rising edge that produced them.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_char_scroller;

    logic CLOCK_50 = 1'b0;
    logic reset;

    always #5 CLOCK_50 = ~CLOCK_50;

    char_scroller_if ifc ();
    char_scroller_if ifc1 ();

    char_scroller #(.TICK_COUNT(4), .CNT_W(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifc.slave)
    );

    char_scroller #(.TICK_COUNT(1), .CNT_W(2)) dut1 (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifc1.slave)
    );

    // One row: inputs held for cyc edges, then outputs compared.
    // win holds the expected window as 5 octal digits, code0 first.
    typedef struct {
        logic        rst;
        logic        en;
        logic        dir;
        logic        restart;
        logic        wr_en;
        logic [2:0]  wa;
        logic [2:0]  wd;
        int          cyc;
        logic [2:0]  pos;
        logic        tick;
        logic [14:0] win;
    } vec_t;

    vec_t vecs [64];
    int   nvec;
    int   n_chk;
    int   n_fail;
    logic [2:0] dm [8];

    task automatic add(input logic rst, input logic en, input logic dir, input logic restart,
                       input logic wr_en, input logic [2:0] wa, input logic [2:0] wd,
                       input int cyc, input logic [2:0] pos, input logic tick,
                       input logic [14:0] win);
        vecs[nvec] = '{rst, en, dir, restart, wr_en, wa, wd, cyc, pos, tick, win};
        nvec++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    function automatic logic [14:0] window();
        return {ifc.code0, ifc.code1, ifc.code2, ifc.code3, ifc.code4};
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nvec   = 0;
        dm     = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};

        //    rst en dir rs wr wa wd cyc pos tick win
        add(0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 15'o01234);  // no tick before 4th cycle
        add(0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 15'o12344);  // first step
        add(0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 15'o12344);  // tick is one cycle
        add(0, 1, 0, 0, 0, 0, 0,  3, 2, 1, 15'o23444);
        add(0, 1, 0, 0, 0, 0, 0,  4, 3, 1, 15'o34444);
        add(0, 1, 0, 0, 0, 0, 0,  4, 4, 1, 15'o44440);
        add(0, 1, 0, 0, 0, 0, 0,  4, 5, 1, 15'o44401);
        add(0, 1, 0, 0, 0, 0, 0,  4, 6, 1, 15'o44012);  // window wraps to slots 0..2
        add(0, 1, 1, 0, 0, 0, 0,  4, 5, 1, 15'o44401);  // right step
        add(0, 1, 1, 0, 0, 0, 0,  4, 4, 1, 15'o44440);
        add(0, 1, 1, 0, 0, 0, 0,  4, 3, 1, 15'o34444);
        add(0, 1, 1, 0, 0, 0, 0,  4, 2, 1, 15'o23444);
        add(0, 1, 1, 0, 0, 0, 0,  4, 1, 1, 15'o12344);
        add(0, 1, 1, 0, 0, 0, 0,  4, 0, 1, 15'o01234);
        add(0, 1, 1, 0, 0, 0, 0,  4, 7, 1, 15'o40123);  // 0 -> 7
        add(0, 1, 1, 0, 0, 0, 0,  2, 7, 0, 15'o40123);  // dir flips mid-count...
        add(0, 1, 0, 0, 0, 0, 0,  2, 0, 1, 15'o01234);  // ...only the step-edge value counts
        add(0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 15'o01234);
        add(0, 1, 1, 0, 0, 0, 0,  1, 7, 1, 15'o40123);
        add(0, 1, 0, 0, 0, 0, 0,  4, 0, 1, 15'o01234);  // 7 -> 0
        add(0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 15'o01234);  // cnt=2
        add(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 15'o01234);  // frozen
        add(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 15'o01234);  // count resumes, not restarted
        add(0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 15'o12344);  // 2 enabled cycles later
        add(0, 1, 1, 0, 0, 0, 0,  4, 0, 1, 15'o01234);
        add(0, 1, 0, 0, 1, 2, 7,  1, 0, 0, 15'o01734);  // write slot 2
        add(0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 15'o01734);
        add(0, 1, 0, 0, 1, 1, 5,  1, 1, 1, 15'o57344);  // write on step edge
        add(0, 1, 0, 0, 0, 0, 0, 16, 5, 1, 15'o44405);
        add(0, 1, 0, 0, 0, 0, 0,  3, 5, 0, 15'o44405);  // cnt=3
        add(0, 1, 0, 1, 1, 0, 6,  1, 0, 0, 15'o65734);  // restart + write
        add(0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 15'o65734);
        add(0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 15'o57344);  // 4 cycles after restart
        add(0, 1, 0, 0, 0, 0, 0,  3, 1, 0, 15'o57344);  // cnt=3
        add(1, 1, 0, 0, 1, 3, 1,  1, 0, 0, 15'o01234);  // reset beats step and write
        add(0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 15'o01234);
        add(0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 15'o12344);  // slot 3 still default

        ifc.en = 0; ifc.dir = 0; ifc.restart = 0; ifc.wr_en = 0; ifc.wr_addr = 0; ifc.wr_data = 0;
        ifc1.en = 0; ifc1.dir = 0; ifc1.restart = 0; ifc1.wr_en = 0; ifc1.wr_addr = 0; ifc1.wr_data = 0;

        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check("reset pos", int'(ifc.pos), 0);
        check("reset tick", int'(ifc.tick), 0);
        check("reset window", int'(window()), int'(15'o01234));

        for (int i = 0; i < nvec; i++) begin
            reset       = vecs[i].rst;
            ifc.en      = vecs[i].en;
            ifc.dir     = vecs[i].dir;
            ifc.restart = vecs[i].restart;
            ifc.wr_en   = vecs[i].wr_en;
            ifc.wr_addr = vecs[i].wa;
            ifc.wr_data = vecs[i].wd;
            repeat (vecs[i].cyc) begin
                @(posedge CLOCK_50);
                #1;
                // one-shot strobes must not repeat across a multi-cycle row
                ifc.restart = 1'b0;
                ifc.wr_en   = 1'b0;
                reset       = 1'b0;
            end
            check($sformatf("row%0d pos", i), int'(ifc.pos), int'(vecs[i].pos));
            check($sformatf("row%0d tick", i), int'(ifc.tick), int'(vecs[i].tick));
            check($sformatf("row%0d window", i), int'(window()), int'(vecs[i].win));
        end

        // Tick cadence: cnt=0 here, so a tick lands on every 4th enabled edge.
        ifc.en  = 1'b1;
        ifc.dir = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK_50);
            #1;
            check($sformatf("cadence%0d tick", i), int'(ifc.tick), (i % 4 == 3) ? 1 : 0);
        end
        check("cadence pos", int'(ifc.pos), 4);

        // TICK_COUNT=1: a step on every enabled cycle.
        ifc1.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            #1;
            check($sformatf("tc1 step%0d tick", i), int'(ifc1.tick), 1);
            check($sformatf("tc1 step%0d pos", i), int'(ifc1.pos), (i + 1) % 8);
            check($sformatf("tc1 step%0d code0", i), int'(ifc1.code0), int'(dm[(i + 1) % 8]));
        end
        ifc1.en = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("tc1 freeze tick", int'(ifc1.tick), 0);
        check("tc1 freeze pos", int'(ifc1.pos), 2);
        ifc1.en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("tc1 resume tick", int'(ifc1.tick), 1);
        check("tc1 resume pos", int'(ifc1.pos), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/char_scroller.md
Name: char_scroller

Overview:
- Upstream feeder for the 3-bit character-code to 7-segment decoder.
- Holds an 8-slot message of 3-bit character codes and rotates it at a divided clock rate.
- Presents a 5-character window, code0..code4, to five decoder instances driving HEX0..HEX4.
- The message is writable at run time, one slot per cycle, for example from SW through a board-level wrapper.

Parameters:
- TICK_COUNT, default 50000000: enabled cycles per scroll step; 1 step/s at CLOCK_50. Legal range 1..2^CNT_W.
- CNT_W, default 26: width of the rate-divider counter.
- RESET_MSG, default 24'o44443210: message loaded at reset. Slot i = RESET_MSG[3i+2:3i], so the default is slot0=0, 1, 2, 3, then slots 4..7 = 4.

Ports:
- CLOCK_50  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the CLOCK_50 rising edge.
- en  in  1  1 = divider runs and scrolling advances; 0 = freeze.
- dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos-1).
- restart  in  1  synchronous soft restart: cnt=0, pos=0, tick=0; message untouched.
- wr_en  in  1  write strobe; one slot written per cycle it is high.
- wr_addr  in  3  slot index 0..7.
- wr_data  in  3  character code to store.
- code0..code4  out  3 each  window characters; code_k = msg[(pos+k) mod 8]; code0 is leftmost.
- pos  out  3  current window start slot.
- tick  out  1  one-cycle pulse, high in the cycle a new pos first appears.

Behaviour:
- State is cnt[CNT_W-1:0], pos[2:0], tick, and msg[0..7][2:0], all registered.
- code0..code4 are pure combinational functions of pos and msg; there are no extra pipeline registers.
- Reset has highest priority and overrides restart, en and wr_en:
  - cnt=0, pos=0, tick=0, msg=RESET_MSG.
  - Outputs in the first post-reset cycle: code0..code4 = 0,1,2,3,4 with the default message.
- restart has next priority: cnt=0, pos=0, tick=0. A wr_en in the same cycle is still performed.
- Divider, applied when not in reset or restart:
  - en=1 and cnt==TICK_COUNT-1: cnt<=0, tick<=1, pos<=pos+1 (dir=0) or pos-1 (dir=1), mod 8.
  - en=1 otherwise: cnt<=cnt+1, tick<=0.
  - en=0: cnt and pos hold, tick<=0. The count is paused, not cleared.
- Step latency:
  - First step occurs TICK_COUNT enabled cycles after reset.
  - pos and all code outputs change on the same edge that raises tick.
  - Subsequent steps occur every TICK_COUNT enabled cycles.
- TICK_COUNT=1: cnt stays 0, tick is high every enabled cycle, pos moves every enabled cycle.
- dir is sampled only at the step edge. Changing dir between steps has no effect until the next step.
- Wrap-around:
  - pos 7 -> 0 on a left step; 0 -> 7 on a right step.
  - The window index (pos+k) is taken mod 8. With pos=6 the window is slots 6,7,0,1,2.
- Write:
  - msg[wr_addr]<=wr_data at the edge where wr_en=1.
  - Visible on any code_k mapped to that slot in the following cycle.
  - Writes are always accepted (no busy), including during a step edge.
  - Simultaneous write and step: both take effect; the outputs show the new pos over the new message.
- Back-to-back writes to the same address: the last one wins. Writes to 8 distinct addresses in 8 cycles load a whole message.
- Codes are passed unmodified; the downstream decoder defines the glyphs.

Test Plan (TICK_COUNT=4 unless noted):
- Reset for 2 cycles, en=1, dir=0:
  - code0..4 = 0,1,2,3,4 and pos=0.
  - First tick in the 4th cycle after reset release, when pos=1 and the window becomes 1,2,3,4,4.
  - Ticks every 4 cycles thereafter; pos goes 2,3,...,7,0 and wraps.
- Run to pos=6: window = 4,4,0,1,2. Set dir=1; the next step gives pos=5 and window 4,4,4,0,1. A further right step from pos=0 gives pos=7.
- en low for 10 cycles mid-count, when cnt=2: no tick, pos holds. After en returns high, the next tick comes 2 enabled cycles later.
- wr_en with addr=2, data=7 while pos=0: code2=7 from the next cycle. A write to addr=1 on the step edge from pos 0 to 1 gives code0 = the new data in the following cycle.
- restart when pos=5, cnt=3, with a simultaneous write of addr=0, data=6: pos=0, tick=0, code0=6. The next tick comes 4 cycles later.
- reset asserted together with wr_en and at a step edge: the message is restored to RESET_MSG, the write is dropped, and pos=0.
- With TICK_COUNT=1: tick is high every cycle and pos increments every cycle.
